// File: rtl/des3_cbc_ctrl.sv
// des3_cbc_ctrl
// Sequencer around the external des3 core. Holds key/IV/mode configuration,
// takes one 64-bit block at a time from a valid/ready input, drives the core,
// waits out its fixed latency, applies the CBC chaining XOR and presents the
// result on a valid/ready output.
//
// Reset asserts asynchronously and releases synchronously through a two-flop
// synchroniser. Every register uses the synchronised reset, so in_ready stays
// low for two clock edges after i_reset falls.

module des3_cbc_ctrl #(
    parameter int CORE_LATENCY = 48
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // configuration
    input  logic        i_cfg_load,
    input  logic [55:0] i_cfg_key1,
    input  logic [55:0] i_cfg_key2,
    input  logic [55:0] i_cfg_key3,
    input  logic [63:0] i_cfg_iv,
    input  logic        i_cfg_decrypt,
    input  logic        i_cfg_cbc,
    // input block stream
    input  logic        i_in_valid,
    input  logic [63:0] i_in_data,
    output logic        o_in_ready,
    // output block stream
    output logic        o_out_valid,
    output logic [63:0] o_out_data,
    input  logic        i_out_ready,
    output logic        o_busy,
    // des3 core interface
    output logic [63:0] o_core_in,
    output logic [55:0] o_core_key1,
    output logic [55:0] o_core_key2,
    output logic [55:0] o_core_key3,
    output logic        o_core_decrypt,
    input  logic [63:0] i_core_out
);

    // state | meaning
    // IDLE  | waiting for a config load or an input block
    // RUN   | block is inside the core, latency counter running
    // DONE  | result presented on the output, waiting for out_ready

    // The counter is loaded with CORE_LATENCY (not CORE_LATENCY-1): core_in
    // becomes stable just after the accepting edge T, core_out is valid just
    // after edge T+CORE_LATENCY, and it is sampled on the following edge.
    localparam int                CNT_W    = $clog2(CORE_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CORE_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_rst_meta;
    logic               r_rst_sync;
    logic               w_rst;

    logic [55:0]        r_key1;
    logic [55:0]        r_key2;
    logic [55:0]        r_key3;
    logic               r_decrypt;
    logic               r_cbc;
    logic [63:0]        r_chain;
    logic [63:0]        r_save;
    logic [63:0]        r_core_in;
    logic [63:0]        r_out_data;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_in_ready;
    logic               w_busy;
    logic               w_cfg_take;
    logic               w_accept;
    logic               w_capture;
    logic               w_release;
    logic [63:0]        w_core_in_nxt;
    logic [63:0]        w_result;

    // Reset synchroniser: asserts immediately, releases on the second edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst = r_rst_sync;

    // Handshake and sequencing events; a config load in IDLE blocks acceptance.
    always_comb begin
        w_cfg_take = (r_state == S_IDLE) && i_cfg_load;
        w_accept   = w_in_ready && i_in_valid;
        w_capture  = (r_state == S_RUN) && (r_cnt == '0);
        w_release  = (r_state == S_DONE) && r_out_valid && i_out_ready;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)  w_state_nxt = S_RUN;
            S_RUN:  if (w_capture) w_state_nxt = S_DONE;
            S_DONE: if (w_release) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, out of reset, and with no config load pending.
    always_comb begin
        w_in_ready = (r_state == S_IDLE) && !i_cfg_load && !w_rst;
        w_busy     = (r_state != S_IDLE);
    end

    // Chaining XORs: pre-whitening for CBC encrypt, post-whitening for CBC decrypt.
    always_comb begin
        w_core_in_nxt = (r_cbc && !r_decrypt) ? (i_in_data ^ r_chain) : i_in_data;
        w_result      = (r_cbc &&  r_decrypt) ? (i_core_out ^ r_chain) : i_core_out;
    end

    // Configuration and chain register; config is frozen outside IDLE.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_key1    <= '0;
            r_key2    <= '0;
            r_key3    <= '0;
            r_decrypt <= 1'b0;
            r_cbc     <= 1'b0;
            r_chain   <= '0;
        end else if (w_cfg_take) begin
            r_key1    <= i_cfg_key1;
            r_key2    <= i_cfg_key2;
            r_key3    <= i_cfg_key3;
            r_decrypt <= i_cfg_decrypt;
            r_cbc     <= i_cfg_cbc;
            r_chain   <= i_cfg_iv;
        end else if (w_capture && r_cbc) begin
            // Next block chains on the ciphertext: fresh output when encrypting,
            // the saved input block when decrypting.
            r_chain   <= r_decrypt ? r_save : i_core_out;
        end
    end

    // Input block capture; core_in then holds until the next accepted block.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_save    <= '0;
            r_core_in <= '0;
        end else if (w_accept) begin
            r_save    <= i_in_data;
            r_core_in <= w_core_in_nxt;
        end
    end

    // Core latency down-counter, terminal count at zero.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result register and output valid, held until the sink takes it.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_busy         = w_busy;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
    assign o_core_in      = r_core_in;
    assign o_core_key1    = r_key1;
    assign o_core_key2    = r_key2;
    assign o_core_key3    = r_key3;
    assign o_core_decrypt = r_decrypt;

endmodule

// File: tb/tb_des3_cbc_ctrl.sv
// tb_des3_cbc_ctrl
// Bench for des3_cbc_ctrl. The des3 core is replaced by a behavioural stand-in:
// an invertible keyed mix behind a CORE_LATENCY-deep pipeline, chosen so the
// all-zero-key vector 8000000000000000 -> 95F8A5E5DD31D900 holds. Expected
// results come from a bench-side model of the controller pushed to a queue.

module tb_des3_cbc_ctrl;

    localparam int L = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_load;
    logic [55:0] cfg_key1, cfg_key2, cfg_key3;
    logic [63:0] cfg_iv;
    logic        cfg_decrypt, cfg_cbc;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [63:0] core_in;
    logic [55:0] core_key1, core_key2, core_key3;
    logic        core_decrypt;
    logic [63:0] core_out;

    des3_cbc_ctrl #(.CORE_LATENCY(L)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cfg_load    (cfg_load),
        .i_cfg_key1    (cfg_key1),
        .i_cfg_key2    (cfg_key2),
        .i_cfg_key3    (cfg_key3),
        .i_cfg_iv      (cfg_iv),
        .i_cfg_decrypt (cfg_decrypt),
        .i_cfg_cbc     (cfg_cbc),
        .i_in_valid    (in_valid),
        .i_in_data     (in_data),
        .o_in_ready    (in_ready),
        .o_out_valid   (out_valid),
        .o_out_data    (out_data),
        .i_out_ready   (out_ready),
        .o_busy        (busy),
        .o_core_in     (core_in),
        .o_core_key1   (core_key1),
        .o_core_key2   (core_key2),
        .o_core_key3   (core_key3),
        .o_core_decrypt(core_decrypt),
        .i_core_out    (core_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] core_f(input logic [63:0] x, input logic [55:0] k1,
                                           input logic [55:0] k2, input logic [55:0] k3,
                                           input logic dec);
        logic [63:0] m;
        logic [63:0] y;
        m = 64'h95F8A5E5DD31D901 ^ {k1, 8'h00} ^ {8'h00, k2} ^ {k3[27:0], k3[55:20]};
        if (!dec) begin
            y = {x[62:0], x[63]} ^ m;
        end else begin
            y = x ^ m;
            y = {y[0], y[63:1]};
        end
        return y;
    endfunction

    // Core stand-in: fixed-latency pipeline fed from the DUT's core-side ports.
    bit [63:0] pipe [L];
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= core_f(core_in, core_key1, core_key2, core_key3, core_decrypt);
    end
    assign core_out = pipe[L-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Controller model
    logic [55:0] m_k1, m_k2, m_k3;
    logic        m_dec, m_cbc;
    logic [63:0] m_chain;
    logic [63:0] m_last;
    logic [63:0] sb [$];

    task automatic model_push(input logic [63:0] d);
        logic [63:0] e;
        if (m_cbc && !m_dec) begin
            e = core_f(d ^ m_chain, m_k1, m_k2, m_k3, 1'b0);
            m_chain = e;
        end else if (m_cbc && m_dec) begin
            e = core_f(d, m_k1, m_k2, m_k3, 1'b1) ^ m_chain;
            m_chain = d;
        end else begin
            e = core_f(d, m_k1, m_k2, m_k3, m_dec);
        end
        m_last = e;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        m_k1 = '0; m_k2 = '0; m_k3 = '0; m_dec = 1'b0; m_cbc = 1'b0; m_chain = '0;
        sb.delete();
    endtask

    task automatic set_cfg(input logic [55:0] k1, input logic [55:0] k2, input logic [55:0] k3,
                           input logic [63:0] iv, input logic dec, input logic cbc);
        cfg_key1 = k1; cfg_key2 = k2; cfg_key3 = k3;
        cfg_iv = iv; cfg_decrypt = dec; cfg_cbc = cbc;
    endtask

    // Load config while IDLE; one-cycle strobe, called at a negedge.
    task automatic load_cfg(input logic [55:0] k1, input logic [55:0] k2, input logic [55:0] k3,
                            input logic [63:0] iv, input logic dec, input logic cbc);
        set_cfg(k1, k2, k3, iv, dec, cbc);
        cfg_load = 1'b1;
        m_k1 = k1; m_k2 = k2; m_k3 = k3; m_dec = dec; m_cbc = cbc; m_chain = iv;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
    endtask

    // Present a block; acc = number of the accepting edge.
    task automatic send(input logic [63:0] d, output int acc);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < L + 20; n++) begin
            #1;
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            model_push(d);
            @(negedge clk);
            acc = cyc;
        end else begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            acc = cyc;
        end
        in_valid = 1'b0;
    endtask

    // Wait for a result, optionally hold out_ready low, then take it.
    task automatic recv(input int stall, output logic [63:0] got, output int vcyc, output int hs);
        bit ok = 0;
        logic [63:0] held;
        out_ready = 1'b0;
        for (int n = 0; n < L + 20; n++) begin
            #1;
            if (out_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("out_timeout", 64'(out_valid), 64'd1);
            got = '0; vcyc = cyc; hs = cyc;
            @(negedge clk);
            return;
        end
        vcyc = cyc;
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, held);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        got = out_data;
        if (sb.size() == 0) check("sb_empty", 64'd0, 64'd1);
        else                check("sb_data", out_data, sb.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        hs = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, c1, c2;
        int acc, vc, hs, cfgc;

        reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0, 1'b0);
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_core_in", core_in, 64'd0);
        check("rst_key1", 64'(core_key1), 64'd0);
        check("rst_decrypt", 64'(core_decrypt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready();

        // ECB encrypt, zero keys, known vector and latency
        load_cfg('0, '0, '0, '0, 1'b0, 1'b0);
        send(64'h8000000000000000, acc);
        recv(0, got, vc, hs);
        check("ecb_enc_kat", got, 64'h95F8A5E5DD31D900);
        check("ecb_enc_latency", 64'(vc - acc), 64'(L + 1));

        // ECB decrypt
        load_cfg('0, '0, '0, '0, 1'b1, 1'b0);
        send(64'h95F8A5E5DD31D900, acc);
        recv(0, got, vc, hs);
        check("ecb_dec_kat", got, 64'h8000000000000000);

        // CBC encrypt, two blocks, then decrypt them back
        load_cfg('0, '0, '0, '0, 1'b0, 1'b1);
        send(64'h8000000000000000, acc);
        c1 = m_last;
        recv(0, got, vc, hs);
        check("cbc_c1_kat", got, 64'h95F8A5E5DD31D900);
        send(64'h8000000000000000, acc);
        c2 = m_last;
        recv(0, got, vc, hs);
        load_cfg('0, '0, '0, '0, 1'b1, 1'b1);
        send(c1, acc);
        recv(0, got, vc, hs);
        check("cbc_dec_p1", got, 64'h8000000000000000);
        send(c2, acc);
        recv(0, got, vc, hs);
        check("cbc_dec_p2", got, 64'h8000000000000000);

        // Backpressure, then next block one cycle after the handshake
        load_cfg(56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h13579BDF02468A, '0, 1'b0, 1'b0);
        send(64'hDEADBEEFCAFEF00D, acc);
        recv(10, got, vc, hs);
        send(64'h0011223344556677, acc);
        check("bp_next_accept", 64'(acc - hs), 64'd1);
        recv(0, got, vc, hs);

        // cfg_load together with in_valid in IDLE: config wins, block next cycle
        set_cfg(56'hA5A5A5A5A5A5A5, 56'h5A5A5A5A5A5A5A, 56'h0F0F0F0F0F0F0F, 64'h1122334455667788, 1'b0, 1'b1);
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hCAFEBABE00000001;
        #1;
        check("cfg_blocks_ready", 64'(in_ready), 64'd0);
        m_k1 = cfg_key1; m_k2 = cfg_key2; m_k3 = cfg_key3;
        m_dec = cfg_decrypt; m_cbc = cfg_cbc; m_chain = cfg_iv;
        @(negedge clk);
        cfg_load = 1'b0;
        cfgc = cyc;
        send(64'hCAFEBABE00000001, acc);
        check("cfg_then_accept", 64'(acc - cfgc), 64'd1);
        check("cfg_key1_taken", 64'(core_key1), 64'(56'hA5A5A5A5A5A5A5));
        recv(0, got, vc, hs);

        // cfg_load during RUN is ignored; both following blocks use the old config
        send(64'h0F1E2D3C4B5A6978, acc);
        repeat (3) @(negedge clk);
        set_cfg(56'h11111111111111, 56'h22222222222222, 56'h33333333333333, 64'hFFFF, 1'b1, 1'b0);
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        #1;
        check("run_cfg_key1", 64'(core_key1), 64'(56'hA5A5A5A5A5A5A5));
        check("run_cfg_decrypt", 64'(core_decrypt), 64'd0);
        @(negedge clk);
        recv(0, got, vc, hs);
        send(64'h8877665544332211, acc);
        recv(0, got, vc, hs);

        // Reset in the middle of RUN
        send(64'h1234567812345678, acc);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_busy", 64'(busy), 64'd0);
        check("midrun_in_ready", 64'(in_ready), 64'd0);
        check("midrun_out_valid", 64'(out_valid), 64'd0);
        check("midrun_key1", 64'(core_key1), 64'd0);
        model_clear();
        @(negedge clk); #1;
        check("rst_hold_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready();

        // Reset while a result is presented: out_valid drops immediately
        load_cfg(56'h00000000000001, '0, '0, '0, 1'b0, 1'b0);
        send(64'hAAAA5555AAAA5555, acc);
        begin
            bit ok = 0;
            for (int n = 0; n < L + 20; n++) begin
                @(negedge clk); #1;
                if (out_valid) begin ok = 1; break; end
            end
            check("done_reached", 64'(ok), 64'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("done_rst_out_valid", 64'(out_valid), 64'd0);
        check("done_rst_out_data", out_data, 64'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ready();

        // Operation after reset with reloaded config
        load_cfg('0, '0, '0, '0, 1'b0, 1'b0);
        send(64'h8000000000000000, acc);
        recv(0, got, vc, hs);
        check("post_rst_kat", got, 64'h95F8A5E5DD31D900);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
